// File: rtl/matrix_sequencer_pkg.sv
// matrix_sequencer_pkg: shared state encodings, dimensions and load-address limits.
package matrix_sequencer_pkg;
    localparam int N = 3;
    localparam logic [3:0] LAST_MAT_ADDR = 4'd8;
    localparam logic [3:0] LAST_VEC_ADDR = 4'd11;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    typedef struct packed {
        logic       v;
        logic [1:0] idx;
    } stage_t;
endpackage

// File: rtl/matrix_result_buf.sv
// matrix_result_buf: three-entry result store with combinational read; address 3 reads as zero.
module matrix_result_buf
    import matrix_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (we && widx != 2'd3) begin
            mem[widx] <= wdata;
        end
    end

    assign rd_data = (rd_addr == 2'd3) ? '0 : mem[rd_addr];
endmodule

// File: rtl/matrix_sequencer.sv
// matrix_sequencer: loads a 3x3 matrix and 3-vector, streams rows to an external
// multiplier and collects the three dot products after a LAT-cycle pipeline.
module matrix_sequencer
    import matrix_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] col_a,
    output logic [WIDTH-1:0] col_b,
    output logic [WIDTH-1:0] col_c,
    output logic [WIDTH-1:0] row_a,
    output logic [WIDTH-1:0] row_b,
    output logic [WIDTH-1:0] row_c,
    input  logic [WIDTH-1:0] keluaran,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [1:0]       state;
    logic [1:0]       row;
    logic [WIDTH-1:0] mat [N*N];
    logic [WIDTH-1:0] vec [N];
    stage_t           sr  [LAT];
    logic [3:0]       base;
    logic [1:0]       vidx;
    logic             issuing;
    logic             cap;

    assign issuing = state == ISSUE;
    assign base    = {1'b0, row, 1'b0} + {2'b00, row};
    assign vidx    = wr_addr[1:0] - 2'd1;
    assign cap     = sr[LAT-1].v;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign col_a   = issuing ? mat[base]        : '0;
    assign col_b   = issuing ? mat[base + 4'd1] : '0;
    assign col_c   = issuing ? mat[base + 4'd2] : '0;
    assign row_a   = issuing ? vec[0] : '0;
    assign row_b   = issuing ? vec[1] : '0;
    assign row_c   = issuing ? vec[2] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            err   <= 1'b0;
            for (int i = 0; i < N*N; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++) vec[i] <= '0;
            for (int i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
            // each issued row travels LAT stages, tagged with its row index
            sr[0] <= '{v: issuing, idx: row};
            for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        row   <= '0;
                        err   <= 1'b0;
                    end
                    if (wr_en) begin
                        if (wr_addr <= LAST_MAT_ADDR) mat[wr_addr] <= wr_data;
                        else if (wr_addr <= LAST_VEC_ADDR) vec[vidx] <= wr_data;
                        else err <= 1'b1;
                    end
                end
                ISSUE: begin
                    row <= row + 2'd1;
                    if (row == 2'd2) state <= DRAIN;
                end
                DRAIN: if (cap && sr[LAT-1].idx == 2'd2) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    matrix_result_buf #(.WIDTH(WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (cap),
        .widx    (sr[LAT-1].idx),
        .wdata   (keluaran),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_matrix_sequencer.sv
// tb_matrix_sequencer: drives LAT=1 and LAT=3 sequencers with shared stimulus;
// a monitor pops expected results and done timing whenever done pulses.
module tb_matrix_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [1:0]   rd_addr = '0;
    logic         busy1, done1, err1, busy3, done3, err3;
    logic [W-1:0] ca1, cb1, cc1, ra1, rb1, rc1, rd1;
    logic [W-1:0] ca3, cb3, cc3, ra3, rb3, rc3, rd3;
    logic [W-1:0] kel1 = '0, p1 = '0, p2 = '0, kel3 = '0;
    logic [W-1:0] m_v [9];
    logic [W-1:0] n_v [3];
    int cyc = 0, vectors = 0, miscompares = 0;

    typedef struct {
        int           due;
        logic [W-1:0] r0, r1, r2;
    } exp_t;
    exp_t q1[$], q3[$], pq[$];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dot(input logic [W-1:0] a, b, c, x, y, z);
        return a * x + b * y + c * z;
    endfunction

    // external multiplier models: one and three register stages
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        kel1 <= dot(ca1, cb1, cc1, ra1, rb1, rc1);
        p1   <= dot(ca3, cb3, cc3, ra3, rb3, rc3);
        p2   <= p1;
        kel3 <= p2;
    end

    matrix_sequencer #(.WIDTH(W), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy1), .done(done1), .err(err1),
        .col_a(ca1), .col_b(cb1), .col_c(cc1), .row_a(ra1), .row_b(rb1), .row_c(rc1),
        .keluaran(kel1), .rd_addr(rd_addr), .rd_data(rd1)
    );

    matrix_sequencer #(.WIDTH(W), .LAT(3)) u3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy3), .done(done3), .err(err3),
        .col_a(ca3), .col_b(cb3), .col_c(cc3), .row_a(ra3), .row_b(rb3), .row_c(rc3),
        .keluaran(kel3), .rd_addr(rd_addr), .rd_data(rd3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // monitor: owns rd_addr, reads the whole buffer every negedge
    initial begin : mon
        logic [W-1:0] v1 [4];
        logic [W-1:0] v3 [4];
        exp_t e;
        forever begin
            @(negedge clk);
            for (int a = 0; a < 4; a++) begin
                rd_addr = 2'(a);
                #1;
                v1[a] = rd1;
                v3[a] = rd3;
            end
            if (done1 === 1'b1) begin
                if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1 done cycle", cyc, e.due);
                    chk("u1 results", {v1[0], v1[1], v1[2], v1[3]}, {e.r0, e.r1, e.r2, 16'h0});
                end
            end
            if (done3 === 1'b1) begin
                if (q3.size() == 0) chk("u3 unexpected done", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("u3 done cycle", cyc, e.due);
                    chk("u3 results", {v3[0], v3[1], v3[2], v3[3]}, {e.r0, e.r1, e.r2, 16'h0});
                end
            end
            if (pq.size() != 0) begin
                e = pq.pop_front();
                chk("u1 peek", {v1[0], v1[1], v1[2], v1[3]}, {e.r0, e.r1, e.r2, 16'h0});
                chk("u3 peek", {v3[0], v3[1], v3[2], v3[3]}, {e.r0, e.r1, e.r2, 16'h0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load();
        for (int i = 0; i < 9; i++) wr(4'(i), m_v[i]);
        for (int j = 0; j < 3; j++) wr(4'(9 + j), n_v[j]);
    endtask

    task automatic go(input logic push, input logic [W-1:0] r0, r1, r2);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (push) begin
            q1.push_back('{cyc + 4, r0, r1, r2});
            q3.push_back('{cyc + 6, r0, r1, r2});
        end
    endtask

    task automatic chk_issue(input string nm, input logic [W-1:0] a, b, c, x, y, z);
        chk({nm, " u1 col"}, {ca1, cb1, cc1}, {a, b, c});
        chk({nm, " u3 col"}, {ca3, cb3, cc3}, {a, b, c});
        chk({nm, " u1 row"}, {ra1, rb1, rc1}, {x, y, z});
        chk({nm, " u3 row"}, {ra3, rb3, rc3}, {x, y, z});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk("reset status", {busy1, done1, err1, busy3, done3, err3}, 6'b0);
        chk_issue("reset", 0, 0, 0, 0, 0, 0);
        pq.push_back('{0, 16'h0, 16'h0, 16'h0});
        rst = 1'b0;
        tick(); tick();

        m_v = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
        n_v = '{16'd1, 16'd2, 16'd3};
        load();
        go(1'b1, 16'd1, 16'd2, 16'd3);
        chk("identity busy", {busy1, busy3}, 2'b11);
        chk_issue("identity r0", 1, 0, 0, 1, 2, 3);
        tick();
        chk_issue("identity r1", 0, 1, 0, 1, 2, 3);
        tick();
        chk_issue("identity r2", 0, 0, 1, 1, 2, 3);
        tick();
        chk_issue("identity drain", 0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        chk("identity idle busy", {busy1, busy3}, 2'b00);

        m_v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        n_v = '{16'd1, 16'd1, 16'd1};
        load();
        go(1'b1, 16'd6, 16'd15, 16'd24);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        pq.push_back('{0, 16'd6, 16'd15, 16'd24});
        tick(); tick();

        wr(4'd13, 16'hFFFF);
        chk("err set", {err1, err3}, 2'b11);
        go(1'b1, 16'd6, 16'd15, 16'd24);
        chk("err cleared", {err1, err3}, 2'b00);
        wr(4'd8, 16'h7777);
        chk("busy write err", {err1, err3}, 2'b00);
        repeat (9) tick();

        m_v = '{9{16'h0100}};
        n_v = '{3{16'h0100}};
        load();
        go(1'b1, 16'h0, 16'h0, 16'h0);
        chk_issue("wrap r0", 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100);
        repeat (9) tick();

        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd5;
        go(1'b1, 16'h0500, 16'h0, 16'h0);
        wr_en = 1'b0;
        chk_issue("same-cycle r0", 16'd5, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100);
        repeat (9) tick();

        go(1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort status", {busy1, done1, busy3, done3}, 4'b0);
        chk_issue("abort", 0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        pq.push_back('{0, 16'h0, 16'h0, 16'h0});
        tick(); tick();
        go(1'b1, 16'h0, 16'h0, 16'h0);
        chk_issue("post-reset r0", 0, 0, 0, 0, 0, 0);
        repeat (10) tick();

        chk("scoreboard drained", q1.size() + q3.size() + pq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
